// File: rtl/pll_loader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// pll_loader_pkg: shared states, register map and mode table for the loader
// Rev 1.0
// ------------------------------------------------------------------------
package pll_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WRITE     = 3'd2,
    ST_TRIGGER   = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_WAIT_LOCK = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  localparam int         N_CFG_BYTES = 20;
  localparam int         DEF_N_MODES = 4;
  localparam logic [4:0] CTRL_ADDR   = 5'd20;
  localparam logic [7:0] CTRL_START  = 8'h01;

  // Contents of pll_modes.hex from the PLL parameter tool; byte 0 of mode 0 is the LSB.
  localparam logic [DEF_N_MODES*N_CFG_BYTES*8-1:0] DEF_MODE_TABLE = {
    160'h96204C55_1020F043_C00F0904_08060000_28000004,
    160'h78123D44_0C18E032_A00E0803_07050000_1E000003,
    160'h5A0B2E31_0810C021_800D0702_06040000_14000002,
    160'h3C0A1F22_04081080_400C0601_05030000_0A000001
  };

endpackage
`default_nettype wire

// File: rtl/pll_mode_rom.sv
`default_nettype none
// ------------------------------------------------------------------------
// pll_mode_rom: registered {mode, index} -> configuration byte lookup
// Rev 1.0
// ------------------------------------------------------------------------
module pll_mode_rom #(
  parameter int N_MODES     = 4,
  parameter int N_CFG_BYTES = 20,
  parameter int MSEL_W      = 2,
  parameter int IDX_W       = 5,
  parameter logic [N_MODES*N_CFG_BYTES*8-1:0] MODE_TABLE = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [MSEL_W-1:0] i_mode,
  input  logic [IDX_W-1:0]  i_index,
  output logic [7:0]        o_byte
);

  localparam int N_ENTRIES = N_MODES * N_CFG_BYTES;
  localparam int ENTRY_W   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  logic [7:0]  rom_mem [N_ENTRIES];
  logic [31:0] entry;
  logic [7:0]  byte_d;
  logic [7:0]  byte_q;

  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_rom
    assign rom_mem[e] = MODE_TABLE[e*8 +: 8];
  end

  // Out-of-table addresses (latched invalid mode) read as zero.
  always_comb begin
    entry  = 32'(i_mode) * 32'(N_CFG_BYTES) + 32'(i_index);
    byte_d = 8'h00;
    if (entry < 32'(N_ENTRIES)) begin
      byte_d = rom_mem[entry[ENTRY_W-1:0]];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign o_byte = byte_q;

endmodule
`default_nettype wire

// File: rtl/pll_mode_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// pll_mode_loader: streams a stored clock mode into the PLL reconfig port
// Rev 1.0
// ------------------------------------------------------------------------
module pll_mode_loader #(
  parameter int         N_MODES      = 4,
  parameter int         N_CFG_BYTES  = pll_loader_pkg::N_CFG_BYTES,
  parameter logic [4:0] CTRL_ADDR    = pll_loader_pkg::CTRL_ADDR,
  parameter int         SETTLE_CYC   = 200,
  parameter int         LOCK_STABLE  = 4,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter logic [N_MODES*N_CFG_BYTES*8-1:0] MODE_TABLE = pll_loader_pkg::DEF_MODE_TABLE
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_load,
  input  logic [$clog2(N_MODES)-1:0] i_mode_sel,
  input  logic                       i_pll_locked,
  output logic [4:0]                 o_addr,
  output logic [7:0]                 o_data_wr,
  output logic                       o_select,
  output logic                       o_wr_req,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  import pll_loader_pkg::*;

  localparam int MSEL_W  = $clog2(N_MODES);
  localparam int IDX_W   = (N_CFG_BYTES > 1) ? $clog2(N_CFG_BYTES) : 1;
  localparam int CNT_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);

  state_e            state_q, state_d;
  logic [MSEL_W-1:0] mode_q,  mode_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [STAB_W-1:0] stab_q,  stab_d;
  logic              error_q, error_d;
  logic [1:0]        lock_sync_q, lock_sync_d;
  logic [7:0]        rom_byte;
  logic              mode_ok;

  pll_mode_rom #(
    .N_MODES     (N_MODES),
    .N_CFG_BYTES (N_CFG_BYTES),
    .MSEL_W      (MSEL_W),
    .IDX_W       (IDX_W),
    .MODE_TABLE  (MODE_TABLE)
  ) u_rom (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_mode    (mode_q),
    .i_index   (idx_q),
    .o_byte    (rom_byte)
  );

  assign lock_sync_d = {lock_sync_q[0], i_pll_locked};
  assign mode_ok     = (32'(i_mode_sel) < 32'(N_MODES));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    error_d   = error_q;
    o_addr    = 5'd0;
    o_data_wr = 8'h00;
    o_select  = 1'b0;
    o_wr_req  = 1'b0;
    o_done    = 1'b0;
    o_busy    = (state_q != ST_IDLE) && (state_q != ST_FINISH);

    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          mode_d  = i_mode_sel;
          idx_d   = '0;
          cnt_d   = '0;
          error_d = !mode_ok;
          state_d = mode_ok ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        o_addr    = 5'(idx_q);
        o_data_wr = rom_byte;
        o_select  = 1'b1;
        o_wr_req  = 1'b1;
        if (idx_q == IDX_W'(N_CFG_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = ST_TRIGGER;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
      // First cycle is a gap so the trigger keeps the two-cycle strobe cadence.
      ST_TRIGGER: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          o_addr    = CTRL_ADDR;
          o_data_wr = CTRL_START;
          o_select  = 1'b1;
          o_wr_req  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          stab_d  = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (stab_q == STAB_W'(LOCK_STABLE)) begin
          state_d = ST_FINISH;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          stab_d = lock_sync_q[1] ? stab_q + STAB_W'(1) : '0;
        end
      end
      ST_FINISH: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      stab_q      <= '0;
      error_q     <= 1'b0;
      lock_sync_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      error_q     <= error_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign o_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_mode_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_pll_mode_loader: randomized loads against a scoreboard of bus writes and done events
// Rev 1.0
// ------------------------------------------------------------------------
module tb_pll_mode_loader;

  localparam int     S         = 200;
  localparam int     LS        = 4;
  localparam int     TO        = 600;
  localparam int     NB        = 20;
  localparam longint NO_GLITCH = -1000;
  localparam longint NEVER     = 1000000;

  localparam logic [4*NB*8-1:0] TB_TABLE = {
    160'h13579BDF_2468ACE0_FEDCBA98_76543210_DDEEFF00,
    160'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_99AABBCC,
    160'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_55667788,
    160'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90_11223344
  };

  logic       clk = 1'b0;
  logic       rst_n, load, lock, load3;
  logic [1:0] msel, msel3;
  logic [4:0] addr, addr3;
  logic [7:0] data, data3;
  logic       sel, wr, busy, done, err;
  logic       sel3, wr3, busy3, done3, err3;

  always #5 clk = ~clk;

  pll_mode_loader #(
    .N_MODES(4), .SETTLE_CYC(S), .LOCK_STABLE(LS), .LOCK_TIMEOUT(TO), .MODE_TABLE(TB_TABLE)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_mode_sel(msel), .i_pll_locked(lock),
    .o_addr(addr), .o_data_wr(data), .o_select(sel), .o_wr_req(wr),
    .o_busy(busy), .o_done(done), .o_error(err)
  );

  pll_mode_loader #(
    .N_MODES(3), .SETTLE_CYC(S), .LOCK_STABLE(LS), .LOCK_TIMEOUT(TO), .MODE_TABLE(TB_TABLE[3*NB*8-1:0])
  ) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_load(load3), .i_mode_sel(msel3), .i_pll_locked(1'b0),
    .o_addr(addr3), .o_data_wr(data3), .o_select(sel3), .o_wr_req(wr3),
    .o_busy(busy3), .o_done(done3), .o_error(err3)
  );

  typedef struct { longint t; logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct { longint t; logic e; } dn_t;

  wr_t    wq[$];
  dn_t    dq[$];
  longint cyc         = 0;
  longint lock_rise   = 0;
  longint lock_glitch = -1;
  int     errors      = 0;
  int     checks      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(bit ok, string name, longint act, longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, act == act ? exp : exp, cyc);
    end
  endfunction

  function automatic logic [7:0] tbl(int m, int k);
    return TB_TABLE[(m*NB + k)*8 +: 8];
  endfunction

  // Lock level the DUT samples at edge e.
  function automatic bit lock_at(longint e);
    return (e >= lock_rise) && (e != lock_glitch);
  endfunction

  // W is the last SETTLE edge; window sample k sees the lock level at edge W+k-2.
  // A run of LS highs completed at sample k gives done at edge W+k+2; no run within
  // the first TO-1 samples means a timeout, done at edge W+TO+1.
  function automatic void model_done(input longint w, output longint d, output bit e);
    int run = 0;
    for (int k = 1; k < TO; k++) begin
      run = lock_at(w + k - 2) ? run + 1 : 0;
      if (run >= LS) begin
        d = w + k + 2;
        e = 1'b0;
        return;
      end
    end
    d = w + TO + 1;
    e = 1'b1;
  endfunction

  initial begin
    lock = 1'b0;
    forever begin
      @(negedge clk);
      lock = lock_at(cyc + 1);
    end
  end

  // Called at a negedge; the load is sampled at edge T = cyc+1.
  task automatic issue_load(int m, longint rise_off, longint glitch_off);
    longint t, w, d;
    bit     e;
    wr_t    x;
    dn_t    y;
    t = cyc + 1;
    w = t + 42 + S;
    lock_rise   = w + rise_off;
    lock_glitch = (glitch_off == NO_GLITCH) ? -1 : w + glitch_off;
    for (int k = 0; k < NB; k++) begin
      x.t = t + 2 + 2*k; x.a = 5'(k); x.d = tbl(m, k);
      wq.push_back(x);
    end
    x.t = t + 42; x.a = 5'd20; x.d = 8'h01;
    wq.push_back(x);
    model_done(w, d, e);
    y.t = d; y.e = e;
    dq.push_back(y);
    load = 1'b1;
    msel = 2'(m);
    @(negedge clk);
    load = 1'b0;
    chk(busy == 1'b1, "busy_at_T+1", longint'(busy), 1);
    chk(err == 1'b0, "error_cleared_on_load", longint'(err), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || dq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 3000, "idle_within_budget", n, 3000);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    wr_t x;
    dn_t y;
    if (rst_n) begin
      if (wr) begin
        if (wq.size() == 0) begin
          chk(1'b0, "unexpected_write", longint'(addr), 0);
        end else begin
          x = wq.pop_front();
          chk(cyc + 1 == x.t, "write_time", cyc + 1, x.t);
          chk(addr == x.a, "write_addr", longint'(addr), longint'(x.a));
          chk(data == x.d, "write_data", longint'(data), longint'(x.d));
          chk(sel == 1'b1, "write_select", longint'(sel), 1);
        end
      end else begin
        chk(addr == 5'd0 && data == 8'h00 && sel == 1'b0, "bus_zero_without_strobe",
            longint'({addr, data, sel}), 0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          y = dq.pop_front();
          chk(cyc + 1 == y.t, "done_time", cyc + 1, y.t);
          chk(err == y.e, "done_error", longint'(err), longint'(y.e));
          chk(busy == 1'b0, "busy_low_at_done", longint'(busy), 0);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (cyc == 40000) begin
      errors++;
      $display("FAIL watchdog: actual=%0d cycles required=under 40000", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    longint r, g;
    int     m;
    rst_n = 1'b0; load = 1'b0; msel = 2'd0; load3 = 1'b0; msel3 = 2'd0;
    repeat (3) @(negedge clk);
    chk({busy, done, err, wr, sel} == 5'b0, "reset_flags", longint'({busy, done, err, wr, sel}), 0);
    chk({addr, data} == 13'd0, "reset_bus", longint'({addr, data}), 0);
    chk({busy3, done3, err3, wr3} == 4'b0, "reset_flags_n3", longint'({busy3, done3, err3, wr3}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 1 with lock already high.
    issue_load(1, -NEVER, NO_GLITCH);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      m = int'($urandom_range(0, 3));
      r = longint'($urandom_range(0, 24)) - 8;
      g = ($urandom_range(0, 1) == 1) ? r + longint'($urandom_range(0, 5)) : NO_GLITCH;
      issue_load(m, r, g);
      wait_idle();
    end

    // High for 3 samples, one low, then high.
    issue_load(2, -1, 2);
    wait_idle();

    // Load with mode 3 while mode 0 is being written.
    issue_load(0, 0, NO_GLITCH);
    repeat (9) @(negedge clk);
    load = 1'b1; msel = 2'd3;
    @(negedge clk);
    load = 1'b0; msel = 2'd0;
    chk(busy == 1'b1, "busy_during_write", longint'(busy), 1);
    wait_idle();

    // Lock never rises.
    issue_load(3, NEVER, NO_GLITCH);
    wait_idle();
    chk(err == 1'b1, "error_sticky_after_timeout", longint'(err), 1);
    issue_load(1, 3, NO_GLITCH);
    wait_idle();

    // Reset during SETTLE.
    issue_load(2, 0, NO_GLITCH);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({busy, done, err, wr, sel} == 5'b0, "midreset_flags", longint'({busy, done, err, wr, sel}), 0);
    chk({addr, data} == 13'd0, "midreset_bus", longint'({addr, data}), 0);
    chk(wq.size() == 0, "midreset_writes_complete", wq.size(), 0);
    dq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_load(3, 5, NO_GLITCH);
    wait_idle();

    // Out-of-range mode on the 3-mode instance.
    load3 = 1'b1; msel3 = 2'd3;
    @(negedge clk);
    load3 = 1'b0; msel3 = 2'd0;
    chk(done3 == 1'b1, "n3_done_at_T+1", longint'(done3), 1);
    chk(err3 == 1'b1, "n3_error_at_T+1", longint'(err3), 1);
    chk(busy3 == 1'b0, "n3_not_busy", longint'(busy3), 0);
    for (int i = 0; i < 6; i++) begin
      chk(wr3 == 1'b0 && sel3 == 1'b0, "n3_no_strobe", longint'({wr3, sel3}), 0);
      @(negedge clk);
      chk(done3 == 1'b0, "n3_single_done", longint'(done3), 0);
    end
    chk(err3 == 1'b1, "n3_error_sticky", longint'(err3), 1);
    chk({addr3, data3} == 13'd0, "n3_bus_zero", longint'({addr3, data3}), 0);

    chk(wq.size() == 0 && dq.size() == 0, "scoreboard_drained", wq.size() + dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
